// File: rtl/alu_demux_collect_pkg.sv
// Shared definitions for the ALU operand demux/collector and its packed-input mux.
//   state_t  : collector FSM states (FILL collects beats, HOLD presents a full frame)
//   lanes_of : lane count derived from the lane address width
package alu_demux_collect_pkg;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   function automatic int lanes_of(input int sel_w);
      return 1 << sel_w;
   endfunction

endpackage

// File: rtl/alu_demux_collect_if.sv
// Handshake bundle between the operand/result producer, the collector and the
// downstream packed-input mux.
//   in_data/in_sel/in_addr_mode/in_valid -> collector, in_ready <- collector
//   out_d/out_lane_valid/out_valid <- collector, out_ready -> collector
//   master : producer/consumer side, slave : collector side
interface alu_demux_collect_if
   import alu_demux_collect_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int SEL_WIDTH  = 3
);
   localparam int LANES = lanes_of(SEL_WIDTH);

   logic [DATA_WIDTH-1:0]       in_data;
   logic [SEL_WIDTH-1:0]        in_sel;
   logic                        in_addr_mode;
   logic                        in_valid;
   logic                        in_ready;
   logic [LANES*DATA_WIDTH-1:0] out_d;
   logic [LANES-1:0]            out_lane_valid;
   logic                        out_valid;
   logic                        out_ready;

   modport master (
      output in_data, in_sel, in_addr_mode, in_valid, out_ready,
      input  in_ready, out_d, out_lane_valid, out_valid
   );

   modport slave (
      input  in_data, in_sel, in_addr_mode, in_valid, out_ready,
      output in_ready, out_d, out_lane_valid, out_valid
   );

endinterface

// File: rtl/alu_demux_collect_lane_reg.sv
// One lane storage register of the collector.
//   clk, rst : clock and synchronous active-high reset (clears the lane)
//   we       : load d on this edge
//   d, q     : lane data in / out
module alu_demux_collect_lane_reg #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst)
         q <= '0;
      else if (we)
         q <= d;
   end

endmodule

// File: rtl/alu_demux_collect.sv
// Collects 2**SEL_WIDTH words, one per accepted beat, into a packed bus for the
// ALU operand mux. Lane i sits at out_d[(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
//   clk, rst : clock, synchronous active-high reset
//   flush    : drop the partial frame and restart collection
//   bus      : slave side of alu_demux_collect_if (input beats, packed frame out)
// Beats are accepted only in FILL. The beat that makes every lane valid moves
// the block to HOLD, where out_d is frozen until the consumer takes the frame.
// Lane data survives handoff and flush; only rst clears it.
module alu_demux_collect
   import alu_demux_collect_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int SEL_WIDTH  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   alu_demux_collect_if.slave    bus
);

   localparam int LANES = lanes_of(SEL_WIDTH);

   state_t                          state;
   logic [SEL_WIDTH-1:0]            wr_ptr;
   logic [SEL_WIDTH-1:0]            tgt;
   logic [LANES-1:0]                lane_valid;
   logic [LANES-1:0]                tgt_oh;
   logic [LANES-1:0]                lv_next;
   logic [LANES-1:0]                lane_we;
   logic [LANES-1:0][DATA_WIDTH-1:0] lane_q;
   logic                            in_ready_q;
   logic                            out_valid_q;
   logic                            accept;

   // in_ready_q is high exactly in FILL, so accept never fires in HOLD.
   assign accept  = bus.in_valid & in_ready_q;
   assign tgt     = bus.in_addr_mode ? bus.in_sel : wr_ptr;
   assign tgt_oh  = LANES'(1) << tgt;
   assign lv_next = lane_valid | (accept ? tgt_oh : '0);

   // A beat offered in a flush cycle is dropped, so flush gates the lane writes.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign lane_we[i] = accept & ~flush & (tgt == SEL_WIDTH'(i));

      alu_demux_collect_lane_reg #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_lane (
         .clk (clk),
         .rst (rst),
         .we  (lane_we[i]),
         .d   (bus.in_data),
         .q   (lane_q[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state       <= ST_FILL;
         wr_ptr      <= '0;
         lane_valid  <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state)
            ST_FILL: begin
               if (accept) begin
                  lane_valid <= lv_next;
                  // Addressed writes leave the auto pointer where it was.
                  if (!bus.in_addr_mode)
                     wr_ptr <= wr_ptr + 1'b1;
                  // Overwrites of a valid lane do not change lv_next, so the
                  // frame completes only once every distinct lane is written.
                  if (&lv_next) begin
                     state       <= ST_HOLD;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (out_valid_q && bus.out_ready) begin
                  state       <= ST_FILL;
                  wr_ptr      <= '0;
                  lane_valid  <= '0;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state       <= ST_FILL;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready       = in_ready_q;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_lane_valid = lane_valid;
   assign bus.out_d          = lane_q;

endmodule

// File: tb/tb_alu_demux_collect.sv
// Self-checking bench for alu_demux_collect (DATA_WIDTH=8, SEL_WIDTH=3).
// The reference model keeps the frame as an array of 8 words, a written-lane
// mask and an auto pointer, and follows the block's rules beat by beat.
module tb_alu_demux_collect;

   localparam int DW = 8;
   localparam int SW = 3;
   localparam int NL = 8;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   alu_demux_collect_if #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

   alu_demux_collect #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // reference model
   logic [DW-1:0] m_data [NL];
   logic [NL-1:0] m_lv;
   int            m_ptr;
   bit            m_hold;

   function automatic logic [NL*DW-1:0] m_bus();
      logic [NL*DW-1:0] b;
      for (int i = 0; i < NL; i++) b[i*DW +: DW] = m_data[i];
      return b;
   endfunction

   task automatic idle();
      rst = 1'b0;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_addr_mode = 1'b0;
      bus.in_sel = '0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
   endtask

   // Advance the model with the inputs currently driven, then clock the DUT.
   task automatic step();
      int lane;
      if (rst) begin
         for (int i = 0; i < NL; i++) m_data[i] = '0;
         m_lv = '0; m_ptr = 0; m_hold = 0;
      end else if (flush) begin
         m_lv = '0; m_ptr = 0; m_hold = 0;
      end else if (m_hold) begin
         if (bus.out_ready) begin
            m_lv = '0; m_ptr = 0; m_hold = 0;
         end
      end else if (bus.in_valid) begin
         lane = bus.in_addr_mode ? int'(bus.in_sel) : m_ptr;
         m_data[lane] = bus.in_data;
         m_lv[lane] = 1'b1;
         if (!bus.in_addr_mode) m_ptr = (m_ptr + 1) % NL;
         if ($countones(m_lv) == NL) m_hold = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [DW-1:0] d, input bit addr, input int sel);
      bus.in_valid = 1'b1;
      bus.in_data = d;
      bus.in_addr_mode = addr;
      bus.in_sel = SW'(sel);
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      tests++;
      if (bus.out_d !== 64'h0) begin
         fails++; $display("FAIL reset_out_d got %h exp %h", bus.out_d, 64'h0);
      end
      tests++;
      if (bus.out_valid !== 1'b0) begin
         fails++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid);
      end
      tests++;
      if (bus.in_ready !== 1'b1) begin
         fails++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
      end
      tests++;
      if (bus.out_lane_valid !== 8'h00) begin
         fails++; $display("FAIL reset_lane_valid got %h exp 00", bus.out_lane_valid);
      end
   endtask

   task automatic test_auto_fill();
      logic [NL*DW-1:0] held;
      idle();
      for (int i = 0; i < NL; i++) begin
         beat(DW'((i + 1) * 8'h11), 1'b0, 0);
         if (i < NL - 1) begin
            tests++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
               fails++;
               $display("FAIL auto_partial beat %0d got valid=%b ready=%b exp valid=0 ready=1",
                        i, bus.out_valid, bus.in_ready);
            end
         end
      end
      tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         fails++;
         $display("FAIL auto_full got valid=%b ready=%b exp valid=1 ready=0",
                  bus.out_valid, bus.in_ready);
      end
      tests++;
      if (bus.out_d !== 64'h8877665544332211) begin
         fails++; $display("FAIL auto_out_d got %h exp %h", bus.out_d, 64'h8877665544332211);
      end
      held = bus.out_d;
      // producer keeps offering beats in HOLD; none may land
      for (int c = 0; c < 5; c++) begin
         bus.in_valid = 1'b1;
         bus.in_data = DW'($urandom);
         bus.in_addr_mode = 1'($urandom);
         bus.in_sel = SW'($urandom);
         step();
         tests++;
         if (bus.out_d !== held || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL hold_frozen cycle %0d got %h valid=%b exp %h valid=1",
                     c, bus.out_d, bus.out_valid, held);
         end
      end
      bus.in_valid = 1'b0;
   endtask

   // Continues from the HOLD frame left by test_auto_fill.
   task automatic test_handoff();
      idle();
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      tests++;
      if (bus.out_valid !== 1'b0 || bus.out_lane_valid !== 8'h00 || bus.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL handoff got valid=%b lv=%h ready=%b exp valid=0 lv=00 ready=1",
                  bus.out_valid, bus.out_lane_valid, bus.in_ready);
      end
      beat(8'h5A, 1'b0, 0);
      tests++;
      // lanes 1..7 keep the previous frame's data
      if (bus.out_d !== 64'h887766554433225A || bus.out_lane_valid !== 8'h01) begin
         fails++;
         $display("FAIL handoff_new_beat got %h lv=%h exp %h lv=01",
                  bus.out_d, bus.out_lane_valid, 64'h887766554433225A);
      end
   endtask

   task automatic test_addressed();
      idle();
      flush = 1'b1;
      step();
      flush = 1'b0;
      beat(8'hAA, 1'b1, 5);
      beat(8'hBB, 1'b1, 5);
      tests++;
      if (bus.out_lane_valid !== 8'h20 || bus.out_d[47:40] !== 8'hBB) begin
         fails++;
         $display("FAIL addr_overwrite got lv=%h lane5=%h exp lv=20 lane5=bb",
                  bus.out_lane_valid, bus.out_d[47:40]);
      end
      for (int k = 0; k < NL; k++) begin
         if (k == 5) continue;
         beat(DW'(8'hC0 + k), 1'b1, k);
         tests++;
         if (bus.out_valid !== m_hold || bus.out_lane_valid !== m_lv) begin
            fails++;
            $display("FAIL addr_fill lane %0d got valid=%b lv=%h exp valid=%b lv=%h",
                     k, bus.out_valid, bus.out_lane_valid, m_hold, m_lv);
         end
      end
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_d !== 64'hC7C6BBC4C3C2C1C0) begin
         fails++;
         $display("FAIL addr_full got valid=%b d=%h exp valid=1 d=%h",
                  bus.out_valid, bus.out_d, 64'hC7C6BBC4C3C2C1C0);
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_ptr_mixed();
      idle();
      beat(8'h01, 1'b0, 0);
      beat(8'h06, 1'b1, 6);
      beat(8'h02, 1'b0, 0);
      tests++;
      if (bus.out_lane_valid !== 8'h43 || bus.out_d[15:0] !== 16'h0201
          || bus.out_d[55:48] !== 8'h06) begin
         fails++;
         $display("FAIL ptr_mixed got lv=%h d=%h exp lv=43", bus.out_lane_valid, bus.out_d);
      end
   endtask

   task automatic test_flush();
      idle();
      flush = 1'b1;
      step();
      flush = 1'b0;
      beat(8'h31, 1'b0, 0);
      beat(8'h32, 1'b0, 0);
      beat(8'h33, 1'b0, 0);
      flush = 1'b1;
      beat(8'hEE, 1'b0, 0);
      flush = 1'b0;
      tests++;
      if (bus.out_lane_valid !== 8'h00 || bus.in_ready !== 1'b1 || bus.out_d[31:24] === 8'hEE) begin
         fails++;
         $display("FAIL flush got lv=%h ready=%b lane3=%h exp lv=00 ready=1 lane3!=ee",
                  bus.out_lane_valid, bus.in_ready, bus.out_d[31:24]);
      end
      beat(8'h77, 1'b0, 0);
      tests++;
      if (bus.out_lane_valid !== 8'h01 || bus.out_d[7:0] !== 8'h77) begin
         fails++;
         $display("FAIL flush_next got lv=%h lane0=%h exp lv=01 lane0=77",
                  bus.out_lane_valid, bus.out_d[7:0]);
      end
   endtask

   task automatic test_reset_hold();
      idle();
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int i = 0; i < NL; i++) beat(DW'($urandom_range(1, 255)), 1'b0, 0);
      tests++;
      if (bus.out_valid !== 1'b1) begin
         fails++; $display("FAIL rsthold_pre got valid=%b exp 1", bus.out_valid);
      end
      rst = 1'b1;
      bus.out_ready = 1'b1;
      step();
      idle();
      tests++;
      if (bus.out_d !== 64'h0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1
          || bus.out_lane_valid !== 8'h00) begin
         fails++;
         $display("FAIL rsthold got d=%h valid=%b ready=%b lv=%h exp d=0 valid=0 ready=1 lv=00",
                  bus.out_d, bus.out_valid, bus.in_ready, bus.out_lane_valid);
      end
   endtask

   task automatic test_random();
      int bad = 0;
      idle();
      for (int c = 0; c < 2000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         flush = ($urandom_range(0, 39) == 0);
         bus.in_valid = 1'($urandom);
         bus.in_addr_mode = ($urandom_range(0, 3) == 0);
         bus.in_sel = SW'($urandom);
         bus.in_data = DW'($urandom);
         bus.out_ready = ($urandom_range(0, 2) == 0);
         step();
         if (bus.out_d !== m_bus() || bus.out_lane_valid !== m_lv
             || bus.out_valid !== m_hold || bus.in_ready !== !m_hold) begin
            bad++;
            if (bad <= 5)
               $display("FAIL random cycle %0d got d=%h lv=%h v=%b r=%b exp d=%h lv=%h v=%b r=%b",
                        c, bus.out_d, bus.out_lane_valid, bus.out_valid, bus.in_ready,
                        m_bus(), m_lv, m_hold, !m_hold);
         end
      end
      idle();
      tests++;
      if (bad != 0) fails++;
   endtask

   initial begin
      idle();
      m_lv = '0; m_ptr = 0; m_hold = 0;
      for (int i = 0; i < NL; i++) m_data[i] = '0;
      test_reset();
      test_auto_fill();
      test_handoff();
      test_addressed();
      test_ptr_mixed();
      test_flush();
      test_reset_hold();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
